// File: rtl/mvu_result_collector.sv
// Captures MVU result writes for one job into a first-word-fall-through FIFO and
// streams them out over valid/ready; reports completion once the job is drained.
module mvu_result_collector #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              stray,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              stray_q, stray_d;
  logic              done_q, done_d;
  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W+DATA_W-1:0] head_s;

  logic empty_s, full_s, push_s, pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = !empty_s && out_ready;
  assign push_s  = (state_q == S_COLLECT) && in_valid && (!full_s || pop_s);

  // Next-state, counter, sticky-flag and pointer logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q;
    stray_d    = stray_q;
    done_d     = (state_q == S_DONE);
    wr_ptr_d   = wr_ptr_q + PW'(push_s);
    rd_ptr_d   = rd_ptr_q + PW'(pop_s);
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          len_d      = cfg_len;
          word_cnt_d = {CNT_W{1'b0}};
          overflow_d = 1'b0;
          stray_d    = 1'b0;
          state_d    = (cfg_len != {CNT_W{1'b0}}) ? S_COLLECT : S_DONE;
        end else if (in_valid) begin
          stray_d = 1'b1;
        end else begin
          stray_d = stray_q;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          if (!push_s) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          if (word_cnt_q != len_q) begin
            word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            word_cnt_d = word_cnt_q;
          end
          if (word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} == len_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DRAIN: begin
        if (in_valid) begin
          stray_d = 1'b1;
        end else begin
          stray_d = stray_q;
        end
        if (empty_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (in_valid) begin
          stray_d = 1'b1;
        end else begin
          stray_d = stray_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= {CNT_W{1'b0}};
      word_cnt_q <= {CNT_W{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      overflow_q <= 1'b0;
      stray_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      stray_q    <= stray_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage; contents need no reset because reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_addr, in_data};
    end
  end

  assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = !empty_s;
  assign out_addr  = out_valid ? head_s[ADDR_W+DATA_W-1:DATA_W] : {ADDR_W{1'b0}};
  assign out_data  = out_valid ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
  assign busy      = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign stray     = stray_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: doc/mvu_result_collector.md
Name: mvu_result_collector

Overview:
- Hardware counterpart to the bench-side job initiator: sits on the mvutop output write port and captures result words the MVU emits during a job.
- Buffers captured words in a FIFO and presents them to a downstream reader (host DMA or checker) over a valid/ready stream.
- Counts words against a programmed job length, then signals job completion once all words have been drained.

Parameters:
DATA_W, 64, result word width
ADDR_W, 12, result word address width
DEPTH, 16, FIFO depth in entries; power of two, at least 2
CNT_W, 16, width of the job-length and word counters

Ports:
clk  in  1  system clock; all logic rising-edge
rst_n  in  1  synchronous active-low reset
cfg_start  in  1  single-cycle job start pulse
cfg_len  in  CNT_W  expected result word count; sampled with cfg_start
in_valid  in  1  MVU result write strobe; no backpressure available
in_addr  in  ADDR_W  MVU result address
in_data  in  DATA_W  MVU result word
out_valid  out  1  FIFO head valid
out_ready  in  1  reader accepts head
out_addr  out  ADDR_W  head address
out_data  out  DATA_W  head data
busy  out  1  high in COLLECT and DRAIN
done  out  1  one-cycle pulse at job end
overflow  out  1  sticky: word dropped because FIFO was full
stray  out  1  sticky: in_valid seen outside COLLECT
word_cnt  out  CNT_W  words received in the current job, including dropped words

Behaviour:
- Reset: clk rising edge with rst_n=0. Takes priority over every other event, including mid-job. Result after reset:
  - FSM in IDLE, FIFO emptied, in-flight data discarded.
  - All outputs 0; out_addr and out_data read 0.
- FSM states are IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - cfg_start=1 latches cfg_len, clears word_cnt, overflow and stray.
  - If cfg_len != 0, go to COLLECT. If cfg_len == 0, go to DONE.
- COLLECT:
  - Each cycle with in_valid=1 increments word_cnt.
  - The word is pushed only if the FIFO is not full, or if a pop happens in the same cycle (out_valid && out_ready). Otherwise the word is dropped and overflow is set.
  - When word_cnt reaches len on this increment, go to DRAIN on the next cycle.
- DRAIN:
  - in_valid sets stray; the word is not pushed.
  - When the FIFO is empty, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - busy is 0 in DONE and IDLE.
- cfg_start is ignored outside IDLE; the current job is not disturbed.
- in_valid in IDLE or DONE sets stray; the word is not pushed and not counted.
- FIFO:
  - Standard first-word-fall-through.
  - A word pushed on edge N is visible with out_valid=1 after edge N, so latency is 1 cycle.
  - Pop happens on out_valid && out_ready.
  - Pointers are ADDR(log2 DEPTH)+1 bits wide and wrap modulo 2*DEPTH. full and empty are derived from the extra MSB.
  - Simultaneous push and pop keeps occupancy unchanged and is legal when full or when empty.
  - A push into an empty FIFO with out_ready=1 does not pop in the same cycle.
- out_valid may fall only after a pop. out_addr and out_data stay stable while out_valid=1 and out_ready=0.
- word_cnt saturates at len and holds until the next cfg_start.

Test Plan:
- Reset, then cfg_start with cfg_len=4. Send 4 consecutive in_valid words (addr 0..3, data 0xA0..0xA3) with out_ready=1 throughout. Expect out stream 0..3 in order, each exactly 1 cycle after its push; done pulses once; overflow=0; word_cnt=4.
- cfg_len=20, DEPTH=16, out_ready=0, 20 back-to-back words. Expect 16 buffered and overflow=1 from the 17th word. Raising out_ready drains exactly 16 words, then done. word_cnt=20.
- Full FIFO, out_ready=1, in_valid=1 on the same cycle. Expect push accepted, no overflow, occupancy stays at 16.
- cfg_len=0. Expect done 2 cycles after cfg_start, busy never 1, no out_valid.
- in_valid pulse while IDLE, then a further in_valid after the count is reached in DRAIN. Expect stray=1 and no extra out words. A second cfg_start clears stray.
- rst_n=0 for 1 cycle mid-COLLECT with 5 words buffered. Expect out_valid=0, busy=0, word_cnt=0 next cycle, and a subsequent job behaves as in the first scenario.
